// File: rtl/puf_resp_framer_tx.sv
// puf_resp_framer_tx
// Captures a 128-bit PUF response and sends it over a UART line as one frame:
// a header byte, 16 payload bytes (most significant byte first), then a CRC-8
// (poly 0x07, init 0x00) over the payload. The 8N1 serializer and baud timing
// are built in.
module puf_resp_framer_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [127:0]   resp,
    output logic           tx_out,
    output logic           busy,
    output logic           tx_done,
    output logic [7:0]     crc_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // The byte-to-byte step is merged into the last stop-bit cycle, so it has
    // no state of its own.
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START_BIT = 2'd1;
    localparam logic [1:0] DATA      = 2'd2;
    localparam logic [1:0] STOP_BIT  = 2'd3;

    localparam logic [4:0] LAST_PAYLOAD_IDX = 5'd16;
    localparam logic [4:0] CRC_IDX          = 5'd17;
    localparam logic [3:0] LAST_DATA_BIT    = 4'd8;

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  clk_cnt_r;
    logic [3:0]        bit_idx_r;
    logic [4:0]        byte_idx_r;
    logic [127:0]      shift_r;
    logic [7:0]        byte_r;
    logic [7:0]        crc_r;
    logic [7:0]        crc_out_r;
    logic              tx_r;
    logic              busy_r;
    logic              done_r;

    logic              bit_end_s;
    logic [7:0]        crc_fold_s;

    // Fold one byte into the CRC-8 (poly 0x07), MSB first.
    function automatic logic [7:0] crc8_fold(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Last cycle of the current bit period.
    always_comb begin
        bit_end_s = (clk_cnt_r == CNT_LAST);
    end

    // CRC after absorbing the payload byte that is loaded next.
    always_comb begin
        crc_fold_s = crc8_fold(crc_r, shift_r[127:120]);
    end

    // Frame sequencer, bit timing and serializer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            clk_cnt_r  <= CNT_ZERO;
            bit_idx_r  <= 4'd0;
            byte_idx_r <= 5'd0;
            shift_r    <= 128'd0;
            byte_r     <= 8'h00;
            crc_r      <= 8'h00;
            crc_out_r  <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    clk_cnt_r <= CNT_ZERO;
                    tx_r      <= 1'b1;
                    if (start) begin
                        shift_r    <= resp;
                        crc_r      <= 8'h00;
                        byte_r     <= HEADER;
                        byte_idx_r <= 5'd0;
                        bit_idx_r  <= 4'd0;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= CNT_ZERO;
                        bit_idx_r <= 4'd1;
                        tx_r      <= byte_r[0];
                        state_r   <= DATA;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= CNT_ZERO;
                        bit_idx_r <= bit_idx_r + 4'd1;
                        if (bit_idx_r == LAST_DATA_BIT) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP_BIT;
                        end else begin
                            tx_r   <= byte_r[1];
                            byte_r <= {1'b0, byte_r[7:1]};
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_ONE;
                    end
                end
                STOP_BIT: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= CNT_ZERO;
                        bit_idx_r <= 4'd0;
                        if (byte_idx_r == CRC_IDX) begin
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            byte_idx_r <= byte_idx_r + 5'd1;
                            tx_r       <= 1'b0;
                            state_r    <= START_BIT;
                            if (byte_idx_r == LAST_PAYLOAD_IDX) begin
                                // Payload is complete: the CRC itself goes out next.
                                byte_r    <= crc_r;
                                crc_out_r <= crc_r;
                            end else begin
                                byte_r  <= shift_r[127:120];
                                shift_r <= {shift_r[119:0], 8'h00};
                                crc_r   <= crc_fold_s;
                            end
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    clk_cnt_r <= CNT_ZERO;
                    tx_r      <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out  = tx_r;
    assign busy    = busy_r;
    assign tx_done = done_r;
    assign crc_out = crc_out_r;

endmodule

// File: tb/tb_puf_resp_framer_tx.sv
// Self-checking bench for puf_resp_framer_tx with a short bit period.
module tb_puf_resp_framer_tx;

    localparam int C = 4;
    localparam int FRAME_CYC = 180 * C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] resp;
    logic         tx_out;
    logic         busy;
    logic         tx_done;
    logic [7:0]   crc_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    puf_resp_framer_tx #(.CLKS_PER_BIT(C), .HEADER(8'hA5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .resp    (resp),
        .tx_out  (tx_out),
        .busy    (busy),
        .tx_done (tx_done),
        .crc_out (crc_out)
    );

    typedef struct {
        logic [127:0] resp;
        logic [7:0]   crc;
        bit           poke;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // CRC as remainder of (message * x^8) mod (x^8 + x^2 + x + 1).
    function automatic logic [7:0] ref_crc(input logic [127:0] r);
        logic [135:0] m;
        m = {r, 8'h00};
        for (int i = 135; i >= 8; i--) begin
            if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        end
        return m[7:0];
    endfunction

    // Frame as 18 bytes, byte j at bits [8j +: 8].
    function automatic logic [143:0] ref_frame(input logic [127:0] r, input logic [7:0] c);
        logic [143:0] f;
        f[7:0] = 8'hA5;
        for (int j = 1; j <= 16; j++) f[8*j +: 8] = r[127 - 8*(j-1) -: 8];
        f[143:136] = c;
        return f;
    endfunction

    // Expected line level in frame cycle k (1..FRAME_CYC).
    function automatic logic ref_line(input logic [143:0] f, input int k);
        int bp, by, b;
        bp = (k - 1) / C;
        by = bp / 10;
        b  = bp % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return f[8*by + b - 1];
    endfunction

    // Start one frame from idle (current cycle = cycle 0) and check it fully.
    task automatic run_frame(input logic [127:0] r, input logic [7:0] c, input bit poke, input string name);
        logic [143:0] f;
        logic [143:0] got;
        int bad;
        int bp, by, b;
        f   = ref_frame(r, c);
        got = '0;
        bad = 0;
        start = 1'b1;
        resp  = r;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= FRAME_CYC; k++) begin
            if (tx_out !== ref_line(f, k) || busy !== 1'b1 || tx_done !== 1'b0) begin
                if (bad == 0)
                    $display("FAIL %s_line: cycle %0d tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                             name, k, tx_out, busy, tx_done, ref_line(f, k));
                bad++;
            end
            bp = (k - 1) / C;
            by = bp / 10;
            b  = bp % 10;
            if ((k - 1) % C == C / 2 && b >= 1 && b <= 8) got[8*by + b - 1] = tx_out;
            if (poke && k == 100) begin
                start = 1'b1;
                resp  = ~r;
            end else if (poke && k == 101) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        check({name, "_line_bad"}, bad, 0);
        for (int j = 0; j < 18; j++) check($sformatf("%s_byte%0d", name, j), got[8*j +: 8], f[8*j +: 8]);
        check({name, "_done"}, tx_done, 1'b1);
        check({name, "_busy_end"}, busy, 1'b0);
        check({name, "_tx_end"}, tx_out, 1'b1);
        check({name, "_crc_out"}, crc_out, c);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, tx_done, 1'b0);
        check({name, "_crc_hold"}, crc_out, c);
    endtask

    initial begin
        int bad;
        int done_q[$];
        logic tx720, tx721, tx722, busy721;
        logic [127:0] r;

        rst_n = 1'b0;
        start = 1'b0;
        resp  = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_crc", crc_out, 8'h00);
        rst_n = 1'b1;

        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (tx_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || crc_out !== 8'h00) bad++;
        end
        check("idle_bad_cycles", bad, 0);

        vecs[0] = '{resp: 128'h0, crc: 8'h00, poke: 1'b0};
        vecs[1] = '{resp: 128'h1, crc: 8'h07, poke: 1'b0};
        vecs[2] = '{resp: 128'hABCDEF9876543210ABCDEF9876543210, crc: 8'h00, poke: 1'b0};
        vecs[2].crc = ref_crc(vecs[2].resp);
        vecs[3] = vecs[2];
        vecs[3].poke = 1'b1;
        for (int i = 4; i < 6; i++) begin
            vecs[i].resp = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].crc  = ref_crc(vecs[i].resp);
            vecs[i].poke = 1'b0;
        end

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].resp, vecs[i].crc, vecs[i].poke, $sformatf("vec%0d", i));
            repeat (3) @(posedge clk);
            #1;
        end

        // Back-to-back: start held high across the first completion.
        r = 128'hABCDEF9876543210ABCDEF9876543210;
        start = 1'b1;
        resp  = r;
        tx720 = 1'b0; tx721 = 1'b0; tx722 = 1'b1; busy721 = 1'b1;
        for (int k = 1; k <= 2 * FRAME_CYC + 20; k++) begin
            @(posedge clk); #1;
            if (tx_done === 1'b1) done_q.push_back(k);
            if (k == FRAME_CYC)     tx720 = tx_out;
            if (k == FRAME_CYC + 1) begin tx721 = tx_out; busy721 = busy; end
            if (k == FRAME_CYC + 2) begin tx722 = tx_out; start = 1'b0; end
        end
        check("b2b_done_count", done_q.size(), 2);
        if (done_q.size() >= 1) check("b2b_done1_cycle", done_q[0], FRAME_CYC + 1);
        if (done_q.size() >= 2) check("b2b_done2_cycle", done_q[1], 2 * FRAME_CYC + 2);
        check("b2b_last_stop", tx720, 1'b1);
        check("b2b_idle_gap", tx721, 1'b1);
        check("b2b_gap_busy", busy721, 1'b0);
        check("b2b_next_start", tx722, 1'b0);
        check("b2b_crc_out", crc_out, ref_crc(r));

        // Reset mid-frame at cycle 300, where the line would otherwise be low.
        start = 1'b1;
        resp  = 128'h0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        check("mid_pre_tx", tx_out, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_async_tx", tx_out, 1'b1);
        check("mid_async_busy", busy, 1'b0);
        check("mid_async_crc", crc_out, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < FRAME_CYC + 50; k++) begin
            @(posedge clk); #1;
            if (tx_done !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mid_after_bad_cycles", bad, 0);
        r = {$urandom, $urandom, $urandom, $urandom};
        run_frame(r, ref_crc(r), 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/puf_resp_framer_tx.md
Name: puf_resp_framer_tx

Overview:
- Downstream stage of the 128-bit PUF core: captures a 128-bit response and transmits it as one framed UART packet.
- Frame is a header byte, 16 payload bytes, then a CRC-8 byte.
- Replaces the bare 128-bit serializer on the PC link, so the host can detect lost or corrupted responses.
- Contains its own baud timing and 8N1 bit serializer; needs no external tx clock.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to send; sampled every clk, honoured only when busy=0.
- resp  input  128  response word; latched on the accepted start cycle.
- tx_out  output  1  UART serial line, idle high.
- busy  output  1  high from the cycle after an accepted start until the frame completes.
- tx_done  output  1  one-cycle pulse at frame completion.
- crc_out  output  8  CRC of the most recently transmitted frame.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: tx_out=1, busy=0, tx_done=0, crc_out=8'h00; internal state IDLE, all counters and shift registers cleared.
- Reset asserted mid-frame: tx_out returns to 1 immediately (asynchronously) and the frame is abandoned. After release the block sits in IDLE and no tx_done is produced.
- Accepted start (start=1 while busy=0):
  - latch resp into a 128-bit shift register;
  - clear the running CRC to 8'h00;
  - load HEADER as the current byte.
- start while busy=1 is ignored; resp is not sampled.
- FSM states:
  - IDLE -> START_BIT on accepted start.
  - START_BIT -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP_BIT after 8 bit periods.
  - STOP_BIT -> NEXT after one bit period.
  - NEXT -> START_BIT while bytes remain, else -> IDLE with tx_done. NEXT is zero-time: it is merged into the last stop-bit cycle and adds no cycle.
- Line format is 8N1:
  - start bit 0, then 8 data bits LSB first, then stop bit 1;
  - each bit held exactly CLKS_PER_BIT cycles, with no inter-byte gap.
- Byte order:
  - byte 0 = HEADER;
  - bytes 1..16 = resp[127:120], resp[119:112], ..., resp[7:0];
  - byte 17 = CRC.
- CRC-8 definition:
  - poly 0x07, init 0x00, MSB-first, no reflection, no final XOR;
  - computed over the 16 payload bytes only (header excluded);
  - each payload byte folds into the CRC when it is loaded for transmission.
- crc_out updates when the CRC byte is loaded and holds until the next frame's CRC byte or reset.
- Timing (accepted start sampled at cycle 0):
  - busy=1 and tx_out=0 (start bit) from cycle 1;
  - frame occupies cycles 1..180*CLKS_PER_BIT (18 bytes x 10 bits);
  - at cycle 180*CLKS_PER_BIT+1: tx_done=1 for one cycle, busy=0, tx_out=1.
- Back-to-back frames: start asserted in the tx_done cycle is accepted (busy=0 there). The next start bit begins the following cycle, one idle-high cycle after the last stop bit.
- start held high continuously: a new frame begins immediately after each completion.
- Counters: bit-period counter counts 0..CLKS_PER_BIT-1, bit index 0..9, byte index 0..17. No wrap beyond 17; reaching the end of byte 17 ends the frame.

Test Plan:
- Reset and idle: hold rst_n=0, then release with start=0 for 100 cycles -> tx_out=1, busy=0, tx_done=0, crc_out=8'h00 throughout.
- Zero response: CLKS_PER_BIT=4, resp=128'h0, start pulse at cycle 0 -> decoded bytes A5, 00 x16, 00; tx_done at cycle 721; crc_out=8'h00.
- LSB-only response: resp=128'h1 -> last payload byte 01, CRC byte 07, crc_out=8'h07.
- Mixed response: resp=128'hABCDEF9876543210ABCDEF9876543210 -> payload bytes AB CD EF 98 76 54 32 10 repeated twice; CRC byte matches a software CRC-8/0x07 model. Ignored-start check: changing resp and pulsing start mid-frame alters neither the frame nor its timing.
- Back-to-back: start=1 held through two frames -> tx_done pulses at cycles 721 and 1442; exactly one idle-high cycle between frames.
- Reset mid-frame: drop rst_n at cycle 300 for 3 cycles -> tx_out=1 asynchronously, no tx_done; a new start after release yields a complete, correct frame.
